// File: rtl/mem_bridge.sv
// Byte-serial bridge between the CPU MOV/MOC memory handshake and a byte-wide
// synchronous RAM; splits/assembles byte, halfword and word accesses big-endian.
module mem_bridge #(
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  typeData,
    input  logic [31:0] ADDR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ERR,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_re,
    output logic        mem_we
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic        rw_reg;
    logic [1:0]  size_reg;
    logic [7:0]  addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;
    logic [1:0]  byte_reg, byte_next;
    logic [2:0]  wait_reg;
    logic [31:0] asm_reg, asm_next, dout_reg;
    logic        moc_reg, err_out_reg, re_reg, we_reg;
    logic [7:0]  maddr_reg, mwdata_reg;

    logic        bad_req, last_wait, last_byte, done_hold;
    logic        cur_rw;
    logic [1:0]  cur_size, cur_last, lane;
    logic [7:0]  cur_addr;
    logic [31:0] cur_data;
    logic        unused_addr;

    assign unused_addr = ^ADDR[31:8];

    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    always_comb begin
        bad_req   = (typeData == 2'b11) ||
                    (typeData == 2'b01 && ADDR[0]) ||
                    (typeData == 2'b10 && ADDR[1:0] != 2'b00);
        last_wait = (wait_reg == 3'(WAIT_STATES - 1));
        last_byte = (byte_reg == last_index(size_reg));
        // Shifting in keeps the first byte most significant and zero-extends.
        asm_next  = {asm_reg[23:0], mem_rdata};
        // MOC always rises for one cycle; after that it tracks MOV.
        done_hold = (state_reg == DONE) && (!moc_reg || MOV);

        state_next = state_reg;
        byte_next  = byte_reg;
        case (state_reg)
            IDLE: begin
                byte_next = 2'd0;
                if (MOV)
                    state_next = bad_req ? DONE : ACCESS;
            end
            ACCESS: state_next = WAIT;
            WAIT: begin
                if (last_wait) begin
                    if (last_byte) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCESS;
                        byte_next  = byte_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                if (moc_reg && !MOV)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // In IDLE the request is still on the inputs; afterwards use the latched copy.
        cur_rw   = (state_reg == IDLE) ? RW       : rw_reg;
        cur_size = (state_reg == IDLE) ? typeData : size_reg;
        cur_addr = (state_reg == IDLE) ? ADDR[7:0] : addr_reg;
        cur_data = (state_reg == IDLE) ? DataIn   : wdata_reg;
        cur_last = last_index(cur_size);
        lane     = cur_last - byte_next;
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_reg   <= IDLE;
            rw_reg      <= 1'b0;
            size_reg    <= 2'b00;
            addr_reg    <= 8'h00;
            wdata_reg   <= 32'h0;
            err_reg     <= 1'b0;
            byte_reg    <= 2'd0;
            wait_reg    <= 3'd0;
            asm_reg     <= 32'h0;
            dout_reg    <= 32'h0;
            moc_reg     <= 1'b0;
            err_out_reg <= 1'b0;
            re_reg      <= 1'b0;
            we_reg      <= 1'b0;
            maddr_reg   <= 8'h00;
            mwdata_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            byte_reg  <= byte_next;

            if (state_reg == IDLE && MOV) begin
                rw_reg    <= RW;
                size_reg  <= typeData;
                addr_reg  <= ADDR[7:0];
                wdata_reg <= DataIn;
                err_reg   <= bad_req;
                asm_reg   <= 32'h0;
            end

            if (state_reg == WAIT && !last_wait)
                wait_reg <= wait_reg + 3'd1;
            else
                wait_reg <= 3'd0;

            if (state_reg == WAIT && last_wait && rw_reg) begin
                asm_reg <= asm_next;
                if (last_byte)
                    dout_reg <= asm_next;
            end

            // Strobes are registered from the next state so they line up with ACCESS.
            re_reg <= (state_next == ACCESS) && cur_rw;
            we_reg <= (state_next == ACCESS) && !cur_rw;
            if (state_next == ACCESS) begin
                maddr_reg <= cur_addr + {6'b0, byte_next};
                if (!cur_rw)
                    mwdata_reg <= cur_data[{lane, 3'b000} +: 8];
            end

            moc_reg     <= done_hold;
            err_out_reg <= done_hold && err_reg;
        end
    end

    assign DataOut   = dout_reg;
    assign MOC       = moc_reg;
    assign ERR       = err_out_reg;
    assign mem_addr  = maddr_reg;
    assign mem_wdata = mwdata_reg;
    assign mem_re    = re_reg;
    assign mem_we    = we_reg;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: two instances (1 and 3 wait states) with behavioural RAMs,
// a request table, and a strobe scoreboard compared after each transaction.
module tb_mem_bridge;

    typedef struct {
        logic        rw;
        logic [1:0]  t;
        logic [7:0]  a;
        logic [31:0] din;
        logic        pulse;
        logic [31:0] exp_dout;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        clr, mov1, mov3, rw;
    logic [1:0]  tdata;
    logic [31:0] addr, din;
    logic [31:0] dout1, dout3;
    logic        moc1, moc3, err1, err3;
    logic [7:0]  ma1, ma3, wd1, wd3, rd1, rd3;
    logic        re1, re3, we1, we3;

    logic [7:0]  ram1 [256];
    logic [7:0]  ram3 [256];
    obs_t        obs1[$];
    obs_t        obs3[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [9];

    always #5 clk = ~clk;

    mem_bridge #(.WAIT_STATES(1)) dut1 (
        .CLK(clk), .CLR(clr), .MOV(mov1), .RW(rw), .typeData(tdata), .ADDR(addr),
        .DataIn(din), .DataOut(dout1), .MOC(moc1), .ERR(err1), .mem_addr(ma1),
        .mem_wdata(wd1), .mem_rdata(rd1), .mem_re(re1), .mem_we(we1)
    );

    mem_bridge #(.WAIT_STATES(3)) dut3 (
        .CLK(clk), .CLR(clr), .MOV(mov3), .RW(rw), .typeData(tdata), .ADDR(addr),
        .DataIn(din), .DataOut(dout3), .MOC(moc3), .ERR(err3), .mem_addr(ma3),
        .mem_wdata(wd3), .mem_rdata(rd3), .mem_re(re3), .mem_we(we3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // RAMs register read data on the strobe edge.
    always @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 256; i++) ram1[i] <= 8'h00;
            ram1[8'h00] <= 8'h5A;
            ram1[8'h10] <= 8'hDE;
            ram1[8'h11] <= 8'hAD;
            ram1[8'h12] <= 8'hBE;
            ram1[8'h13] <= 8'hEF;
            ram1[8'hFF] <= 8'h80;
            rd1 <= 8'h00;
        end else begin
            if (re1) rd1 <= ram1[ma1];
            if (we1) ram1[ma1] <= wd1;
        end
    end

    always @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 256; i++) ram3[i] <= 8'h00;
            rd3 <= 8'h00;
        end else begin
            if (re3) rd3 <= ram3[ma3];
            if (we3) ram3[ma3] <= wd3;
        end
    end

    always @(negedge clk) begin
        if (re1 || we1) obs1.push_back('{we1, ma1, wd1, cyc});
        if (re3 || we3) obs3.push_back('{we3, ma3, wd3, cyc});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_moc(input int sel);
        return (sel == 3) ? moc3 : moc1;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 3) ? err3 : err1;
    endfunction

    task automatic set_mov(input int sel, input logic v);
        if (sel == 3) mov3 = v;
        else mov1 = v;
    endtask

    task automatic run_req(input int sel, input vec_t v, input string tag);
        int          n, lat, exp_n, gap;
        logic        moc_v, err_v;
        logic [31:0] dout_v, tmp;
        obs_t        got[$];

        n   = (v.t == 2'b00) ? 1 : (v.t == 2'b01) ? 2 : 4;
        gap = (sel == 3) ? 4 : 2;
        @(negedge clk);
        rw    = v.rw;
        tdata = v.t;
        addr  = {24'h5A5A5A, v.a};
        din   = v.din;
        set_mov(sel, 1'b1);
        @(posedge clk);
        #1;
        // Scramble request inputs after acceptance; the bridge must ignore them.
        rw    = ~rw;
        din   = ~din;
        addr  = ~addr;
        tdata = 2'b11;
        if (v.pulse) set_mov(sel, 1'b0);

        lat   = 0;
        moc_v = 1'b0;
        while (!moc_v && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
            moc_v = get_moc(sel);
        end
        err_v  = get_err(sel);
        dout_v = (sel == 3) ? dout3 : dout1;
        chk({tag, " moc_latency"}, lat, v.exp_lat);
        chk({tag, " err"}, {31'b0, err_v}, {31'b0, v.exp_err});
        chk({tag, " dataout"}, dout_v, v.exp_dout);

        if (v.pulse) begin
            @(posedge clk);
            #1;
            chk({tag, " moc_one_cycle"}, {31'b0, get_moc(sel)}, 32'h0);
        end else begin
            repeat (2) begin
                @(posedge clk);
                #1;
                chk({tag, " moc_held"}, {31'b0, get_moc(sel)}, 32'h1);
            end
            set_mov(sel, 1'b0);
            @(posedge clk);
            #1;
            chk({tag, " moc_drop"}, {31'b0, get_moc(sel)}, 32'h0);
            chk({tag, " err_drop"}, {31'b0, get_err(sel)}, 32'h0);
        end

        if (sel == 3) begin got = obs3; obs3.delete(); end
        else begin got = obs1; obs1.delete(); end
        exp_n = v.exp_err ? 0 : n;
        chk({tag, " strobe_count"}, got.size(), exp_n);
        for (int k = 0; k < exp_n && k < got.size(); k++) begin
            chk({tag, " strobe_kind"}, {31'b0, got[k].we}, {31'b0, ~v.rw});
            chk({tag, " strobe_addr"}, {24'b0, got[k].addr}, {24'b0, v.a + 8'(k)});
            if (!v.rw) begin
                tmp = v.din >> (8 * (n - 1 - k));
                chk({tag, " wdata"}, {24'b0, got[k].data}, {24'b0, tmp[7:0]});
            end
            if (k > 0)
                chk({tag, " strobe_gap"}, got[k].cyc - got[k-1].cyc, gap);
        end
        $display("txn %s: dut=%0d rw=%0d type=%0d addr=%h lat=%0d dout=%h err=%0d strobes=%0d",
                 tag, sel, v.rw, v.t, v.a, lat, dout_v, err_v, got.size());
    endtask

    initial begin
        vec_t v;
        //         rw    type   addr   din           pulse dout          err  lat
        vecs[0] = '{1'b1, 2'b10, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 9};
        vecs[1] = '{1'b0, 2'b01, 8'h22, 32'h1234ABCD, 1'b0, 32'hDEADBEEF, 1'b0, 5};
        vecs[2] = '{1'b1, 2'b00, 8'hFF, 32'h0,        1'b0, 32'h00000080, 1'b0, 3};
        vecs[3] = '{1'b0, 2'b10, 8'h41, 32'h11223344, 1'b0, 32'h00000080, 1'b1, 1};
        vecs[4] = '{1'b1, 2'b11, 8'h40, 32'h0,        1'b0, 32'h00000080, 1'b1, 1};
        vecs[5] = '{1'b1, 2'b01, 8'h22, 32'h0,        1'b0, 32'h0000ABCD, 1'b0, 5};
        vecs[6] = '{1'b0, 2'b10, 8'h30, 32'hCAFEF00D, 1'b1, 32'h0000ABCD, 1'b0, 9};
        vecs[7] = '{1'b1, 2'b10, 8'h30, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 9};
        vecs[8] = '{1'b1, 2'b01, 8'h13, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 1};

        clr = 1'b0; mov1 = 1'b0; mov3 = 1'b0; rw = 1'b0;
        tdata = 2'b00; addr = 32'h0; din = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dataout", dout1, 32'h0);
        chk("reset moc", {31'b0, moc1}, 32'h0);
        chk("reset err", {31'b0, err1}, 32'h0);
        chk("reset strobes", {30'b0, re1, we1}, 32'h0);
        chk("reset mem_addr", {24'b0, ma1}, 32'h0);
        chk("reset moc3", {31'b0, moc3}, 32'h0);
        clr = 1'b1;
        obs1.delete();
        obs3.delete();

        for (int i = 0; i < 9; i++)
            run_req(1, vecs[i], $sformatf("vec%0d", i));

        // Reset during the second WAIT of a word read.
        @(negedge clk);
        rw = 1'b1; tdata = 2'b10; addr = 32'h10; mov1 = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        mov1 = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset state_outputs", {29'b0, moc1, err1, re1 | we1}, 32'h0);
        chk("midreset dataout", dout1, 32'h0);
        chk("midreset mem_addr", {24'b0, ma1}, 32'h0);
        @(posedge clk);
        #1;
        chk("midreset no_strobe", {30'b0, re1, we1}, 32'h0);
        clr = 1'b1;
        obs1.delete();
        $display("txn midreset: word read aborted by reset");
        v = '{1'b1, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0000005A, 1'b0, 3};
        run_req(1, v, "after_reset");

        // Three wait states: pulsed word write, then read back.
        v = '{1'b0, 2'b10, 8'h44, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 17};
        run_req(3, v, "ws3_write");
        v = '{1'b1, 2'b10, 8'h44, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 17};
        run_req(3, v, "ws3_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Byte-serial memory bridge between the CPU datapath (MAR/MDR, control unit MOV/MOC handshake) and a byte-wide synchronous RAM. It converts one byte, halfword or word request into a sequence of single-byte RAM accesses and assembles or splits the data big-endian. It signals completion on MOC, so the control unit's memory-wait states run unchanged. It flags misaligned or illegal-size requests on ERR without touching memory.

## Interface
Parameters:
- WAIT_STATES, 1, cycles between a RAM strobe and the capture of mem_rdata; legal range 1..7.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- CLR  in  1  synchronous active-low reset, sampled on rising edge of CLK.
- MOV  in  1  memory operation valid (request) from control unit.
- RW  in  1  1 = read, 0 = write; sampled with MOV.
- typeData  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ADDR  in  32  byte address from MAR; only ADDR[7:0] is used.
- DataIn  in  32  write data from MDR, right-aligned.
- DataOut  out  32  read data, right-aligned, zero-extended.
- MOC  out  1  memory operation complete.
- ERR  out  1  request rejected; valid only while MOC=1.
- mem_addr  out  8  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte.
- mem_re  out  1  RAM read strobe, one cycle per byte.
- mem_we  out  1  RAM write strobe, one cycle per byte.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- Reset (CLR=0 at an edge): state IDLE; DataOut, MOC, ERR, mem_addr, mem_wdata, mem_re and mem_we are all 0; byte and wait counters are 0. This applies mid-transfer too: the next cycle shows no strobe.
- IDLE: with MOV=1, latch RW, typeData, ADDR[7:0] and DataIn. Set N = 1, 2 or 4.
  - If typeData=11, or halfword with ADDR[0]=1, or word with ADDR[1:0]≠0, go to DONE with ERR pending and no RAM access.
  - Otherwise go to ACCESS with byte index k=0.
- ACCESS (one cycle):
  - mem_addr = A+k.
  - Read: mem_re=1.
  - Write: mem_we=1 and mem_wdata = latched DataIn[8*(N-1-k)+7 : 8*(N-1-k)], most significant byte at the lowest address.
  - Next state: WAIT.
- WAIT (WAIT_STATES cycles): strobes are 0 and mem_addr is held.
  - On the last WAIT cycle of a read, capture mem_rdata into assembly byte position N-1-k.
  - Then k+1; go to ACCESS if k+1<N, else DONE.
- Alignment guarantees A+k never wraps past 0xFF.
- DONE: MOC=1.
  - For a completed read, DataOut is updated on entry to DONE with the assembled value; upper unused bytes are 0.
  - Writes and errors leave DataOut unchanged.
  - ERR=1 only for rejected requests.
  - DONE is held while MOV=1 (four-phase handshake). When MOV=0, go to IDLE; MOC and ERR drop the same edge.
- MOV falling mid-transfer is ignored. The transfer completes, DONE is entered, MOC is high for exactly one cycle, then IDLE.
- RW, typeData, ADDR and DataIn changes after acceptance are ignored. A new request needs MOV low for at least one IDLE cycle.
- DataOut holds its value until the next completed read or reset.

## Timing
- Each byte takes 1+WAIT_STATES cycles.
- MOC rises N*(1+WAIT_STATES)+1 rising edges after the edge that samples MOV=1 in IDLE. With WAIT_STATES=1: byte 3, halfword 5, word 9.
- Rejected request: MOC and ERR rise 1 edge after acceptance.
- The RAM must present mem_rdata for address mem_addr by the last WAIT cycle. A RAM registered on the strobe edge meets this with WAIT_STATES=1.
- Minimum spacing between requests: MOC high to MOV low, plus 1 IDLE cycle.

## Test plan
- Word read, WAIT_STATES=1, RAM[0x10..0x13]=DE AD BE EF, MOV held high: mem_re pulses at 0x10–0x13 on alternate cycles; MOC rises 9 edges after acceptance; DataOut=0xDEADBEEF; ERR=0; MOC stays high until MOV drops, then falls the same edge.
- Halfword write, ADDR=0x22, DataIn=0x1234ABCD: two mem_we pulses, writing AB at 0x22 then CD at 0x23; MOC at 5 edges; DataOut unchanged.
- Byte read at 0xFF, RAM[0xFF]=0x80: DataOut=0x00000080; MOC at 3 edges.
- Misaligned word at 0x41, and typeData=11 at 0x40: no mem_re or mem_we; MOC=ERR=1 one edge after acceptance; both clear when MOV drops.
- Reset mid-transfer (CLR=0 during second WAIT of a word read): next cycle state is IDLE with all outputs 0. A following byte read at 0x00 completes normally in 3 edges.
- MOV pulsed for one cycle on a word write, and a separate run with WAIT_STATES=3: all 4 bytes are written; MOC is high for exactly one cycle; with WAIT_STATES=3, MOC arrives at 17 edges.
